rx_packet_fifo: RTL and testbench

Single-clock, parametrised receive buffer that takes multi-channel sample sets from the decimation stage, serialises them into one word stream, and hands them to the USB side in fixed-length packets. It replaces the fixed 16-bit, 512-deep, single-channel buffer and its external packet-ready logic. It adds:
- channel serialisation
- atomic sample-set admission
- burst packet reads
- sticky overflow and overrun status

It sits between the strobe-gated decimator outputs and the USB packet engine.

---
 rtl/rx_packet_fifo.sv | 223 ++++++++++++++++++++++
 tb/tb_rx_packet_fifo.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_packet_fifo.sv
`default_nettype none
// ============================================================================
// Module      : rx_packet_fifo
// Description : Receive buffer that serialises multi-channel sample sets into
//               one word stream and releases them in fixed-length bursts.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_packet_fifo #(
    parameter int WIDTH      = 16,
    parameter int ADDR_W     = 9,
    parameter int CHANNELS   = 2,
    parameter int PACKET_LEN = 256
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      wr_strobe,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic                      rd_start,
    input  logic                      clear_status,
    output logic [WIDTH-1:0]          rd_data,
    output logic                      rd_valid,
    output logic                      packet_rdy,
    output logic [ADDR_W:0]           used,
    output logic                      empty,
    output logic                      full,
    output logic                      overflow,
    output logic                      overrun
);

    localparam int                  c_DEPTH     = 2 ** ADDR_W;
    localparam int                  c_IDX_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [ADDR_W:0]     c_DEPTH_U   = (ADDR_W+1)'(c_DEPTH);
    localparam logic [ADDR_W:0]     c_CHAN_U    = (ADDR_W+1)'(CHANNELS);
    localparam logic [ADDR_W:0]     c_PLEN_U    = (ADDR_W+1)'(PACKET_LEN);
    localparam logic [ADDR_W:0]     c_PLEN_LAST = (ADDR_W+1)'(PACKET_LEN - 1);
    localparam logic [c_IDX_W-1:0]  c_CH_LAST   = c_IDX_W'(CHANNELS - 1);

    localparam logic [0:0] c_SER_IDLE  = 1'b0;
    localparam logic [0:0] c_SER_SHIFT = 1'b1;
    localparam logic [0:0] c_RD_IDLE   = 1'b0;
    localparam logic [0:0] c_RD_BURST  = 1'b1;

    logic [WIDTH-1:0]          r_mem [c_DEPTH];

    logic [0:0]                r_ser_state;
    logic [0:0]                w_ser_nxt;
    logic [c_IDX_W-1:0]        r_ch_idx;
    logic [c_IDX_W-1:0]        w_ch_idx_nxt;
    logic [CHANNELS*WIDTH-1:0] r_set;
    logic [ADDR_W-1:0]         r_wr_ptr;

    logic [0:0]                r_rd_state;
    logic [0:0]                w_rd_nxt;
    logic [ADDR_W:0]           r_rd_cnt;
    logic [ADDR_W:0]           w_rd_cnt_nxt;
    logic [ADDR_W-1:0]         r_rd_ptr;

    logic [ADDR_W:0]           r_used;
    logic [ADDR_W:0]           w_used_nxt;
    logic                      r_empty;
    logic                      r_full;
    logic                      r_pkt_rdy;
    logic                      r_overflow;
    logic                      r_overrun;
    logic [WIDTH-1:0]          r_rd_data;
    logic                      r_rd_valid;

    logic [ADDR_W:0]           w_space;
    logic                      w_has_room;
    logic                      w_ser_busy;
    logic                      w_accept;
    logic                      w_drop;
    logic                      w_overrun_evt;
    logic                      w_wr_en;
    logic                      w_rd_accept;
    logic                      w_rd_issue;

    // Admission looks at the registered fill level; same-cycle reads can only
    // add room, so a set admitted here always fits.
    assign w_space       = c_DEPTH_U - r_used;
    assign w_has_room    = (w_space >= c_CHAN_U);
    assign w_ser_busy    = (r_ser_state == c_SER_SHIFT);
    assign w_accept      = !w_ser_busy && wr_strobe && w_has_room;
    assign w_drop        = !w_ser_busy && wr_strobe && !w_has_room;
    assign w_overrun_evt = w_ser_busy && wr_strobe;
    assign w_wr_en       = w_ser_busy;
    assign w_rd_accept   = (r_rd_state == c_RD_IDLE) && rd_start && r_pkt_rdy;
    assign w_rd_issue    = (r_rd_state == c_RD_BURST);

    always_comb begin
        w_ser_nxt    = r_ser_state;
        w_ch_idx_nxt = r_ch_idx;
        case (r_ser_state)
            c_SER_IDLE: begin
                if (w_accept) begin
                    w_ser_nxt    = c_SER_SHIFT;
                    w_ch_idx_nxt = '0;
                end
            end
            c_SER_SHIFT: begin
                if (r_ch_idx == c_CH_LAST) begin
                    w_ser_nxt    = c_SER_IDLE;
                    w_ch_idx_nxt = '0;
                end else begin
                    w_ch_idx_nxt = r_ch_idx + c_IDX_W'(1);
                end
            end
            default: begin
                w_ser_nxt    = c_SER_IDLE;
                w_ch_idx_nxt = '0;
            end
        endcase
    end

    always_comb begin
        w_rd_nxt     = r_rd_state;
        w_rd_cnt_nxt = r_rd_cnt;
        case (r_rd_state)
            c_RD_IDLE: begin
                if (w_rd_accept) begin
                    w_rd_nxt     = c_RD_BURST;
                    w_rd_cnt_nxt = '0;
                end
            end
            c_RD_BURST: begin
                if (r_rd_cnt == c_PLEN_LAST) begin
                    w_rd_nxt     = c_RD_IDLE;
                    w_rd_cnt_nxt = '0;
                end else begin
                    w_rd_cnt_nxt = r_rd_cnt + (ADDR_W+1)'(1);
                end
            end
            default: begin
                w_rd_nxt     = c_RD_IDLE;
                w_rd_cnt_nxt = '0;
            end
        endcase
    end

    always_comb begin
        w_used_nxt = r_used;
        if (w_wr_en && !w_rd_issue) begin
            w_used_nxt = r_used + (ADDR_W+1)'(1);
        end else if (!w_wr_en && w_rd_issue) begin
            w_used_nxt = r_used - (ADDR_W+1)'(1);
        end
    end

    // Storage array carries no reset so it can map onto block RAM.
    always_ff @(posedge clock) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= r_set[WIDTH-1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ser_state <= c_SER_IDLE;
            r_ch_idx    <= '0;
            r_set       <= '0;
            r_wr_ptr    <= '0;
        end else begin
            r_ser_state <= w_ser_nxt;
            r_ch_idx    <= w_ch_idx_nxt;
            if (w_accept) begin
                r_set <= data_in;
            end else if (w_ser_busy) begin
                r_set <= r_set >> WIDTH;
            end
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rd_state <= c_RD_IDLE;
            r_rd_cnt   <= '0;
            r_rd_ptr   <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_state <= w_rd_nxt;
            r_rd_cnt   <= w_rd_cnt_nxt;
            r_rd_valid <= w_rd_issue;
            if (w_rd_issue) begin
                r_rd_data <= r_mem[r_rd_ptr];
                r_rd_ptr  <= r_rd_ptr + ADDR_W'(1);
            end
        end
    end

    // Status is computed from next-state values so it lines up with used.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_used     <= '0;
            r_empty    <= 1'b1;
            r_full     <= 1'b0;
            r_pkt_rdy  <= 1'b0;
            r_overflow <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_used     <= w_used_nxt;
            r_empty    <= (w_used_nxt == '0);
            r_full     <= (w_used_nxt == c_DEPTH_U);
            r_pkt_rdy  <= (w_used_nxt >= c_PLEN_U) && (w_rd_nxt == c_RD_IDLE);
            r_overflow <= w_drop | (r_overflow & ~clear_status);
            r_overrun  <= w_overrun_evt | (r_overrun & ~clear_status);
        end
    end

    assign rd_data    = r_rd_data;
    assign rd_valid   = r_rd_valid;
    assign packet_rdy = r_pkt_rdy;
    assign used       = r_used;
    assign empty      = r_empty;
    assign full       = r_full;
    assign overflow   = r_overflow;
    assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_rx_packet_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_rx_packet_fifo
// Description : Directed bench for rx_packet_fifo across three configurations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_packet_fifo;

    logic clock = 1'b0;
    always #5 clock = ~clock;
    logic reset;

    // a: ADDR_W=5, CHANNELS=2, PACKET_LEN=16
    logic        a_wr_strobe, a_rd_start, a_clear_status;
    logic [31:0] a_data_in;
    logic [15:0] a_rd_data;
    logic        a_rd_valid, a_packet_rdy, a_empty, a_full, a_overflow, a_overrun;
    logic [5:0]  a_used;
    // b: ADDR_W=4, CHANNELS=1, PACKET_LEN=16 (packet equals depth)
    logic        b_wr_strobe, b_rd_start, b_clear_status;
    logic [15:0] b_data_in;
    logic [15:0] b_rd_data;
    logic        b_rd_valid, b_packet_rdy, b_empty, b_full, b_overflow, b_overrun;
    logic [4:0]  b_used;
    // c: ADDR_W=4, CHANNELS=3, PACKET_LEN=16
    logic        c_wr_strobe, c_rd_start, c_clear_status;
    logic [47:0] c_data_in;
    logic [15:0] c_rd_data;
    logic        c_rd_valid, c_packet_rdy, c_empty, c_full, c_overflow, c_overrun;
    logic [4:0]  c_used;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q [$];

    rx_packet_fifo #(.WIDTH(16), .ADDR_W(5), .CHANNELS(2), .PACKET_LEN(16)) u_a (
        .clock(clock), .reset(reset), .wr_strobe(a_wr_strobe), .data_in(a_data_in),
        .rd_start(a_rd_start), .clear_status(a_clear_status), .rd_data(a_rd_data),
        .rd_valid(a_rd_valid), .packet_rdy(a_packet_rdy), .used(a_used), .empty(a_empty),
        .full(a_full), .overflow(a_overflow), .overrun(a_overrun));

    rx_packet_fifo #(.WIDTH(16), .ADDR_W(4), .CHANNELS(1), .PACKET_LEN(16)) u_b (
        .clock(clock), .reset(reset), .wr_strobe(b_wr_strobe), .data_in(b_data_in),
        .rd_start(b_rd_start), .clear_status(b_clear_status), .rd_data(b_rd_data),
        .rd_valid(b_rd_valid), .packet_rdy(b_packet_rdy), .used(b_used), .empty(b_empty),
        .full(b_full), .overflow(b_overflow), .overrun(b_overrun));

    rx_packet_fifo #(.WIDTH(16), .ADDR_W(4), .CHANNELS(3), .PACKET_LEN(16)) u_c (
        .clock(clock), .reset(reset), .wr_strobe(c_wr_strobe), .data_in(c_data_in),
        .rd_start(c_rd_start), .clear_status(c_clear_status), .rd_data(c_rd_data),
        .rd_valid(c_rd_valid), .packet_rdy(c_packet_rdy), .used(c_used), .empty(c_empty),
        .full(c_full), .overflow(c_overflow), .overrun(c_overrun));

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic a_send(input logic [15:0] ch0, input logic [15:0] ch1);
        a_data_in   = {ch1, ch0};
        a_wr_strobe = 1'b1;
        tick();
        a_wr_strobe = 1'b0;
        exp_q.push_back(ch0);
        exp_q.push_back(ch1);
        tick();
        tick();
    endtask

    task automatic a_burst(input string name);
        logic [15:0] want;
        total++; if (a_packet_rdy !== 1'b1) begin bad++; $display("FAIL %s_rdy_before got=%b want=1", name, a_packet_rdy); end
        a_rd_start = 1'b1;
        tick();
        a_rd_start = 1'b0;
        total++; if (a_packet_rdy !== 1'b0) begin bad++; $display("FAIL %s_rdy_drop got=%b want=0", name, a_packet_rdy); end
        for (int i = 0; i < 16; i++) begin
            tick();
            want = 16'hxxxx;
            if (exp_q.size() > 0) want = exp_q.pop_front();
            total++;
            if (a_rd_valid !== 1'b1 || a_rd_data !== want) begin
                bad++; $display("FAIL %s_word%0d got valid=%b data=%h want valid=1 data=%h", name, i, a_rd_valid, a_rd_data, want);
            end
        end
        tick();
        total++; if (a_rd_valid !== 1'b0) begin bad++; $display("FAIL %s_valid_end got=%b want=0", name, a_rd_valid); end
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (a_used !== 6'd0) begin bad++; $display("FAIL reset_used got=%0d want=0", a_used); end
        total++; if (a_empty !== 1'b1 || a_full !== 1'b0) begin bad++; $display("FAIL reset_empty_full got=%b%b want=10", a_empty, a_full); end
        total++; if (a_rd_valid !== 1'b0 || a_rd_data !== 16'h0) begin bad++; $display("FAIL reset_rd got valid=%b data=%h want 0/0000", a_rd_valid, a_rd_data); end
        total++; if (a_packet_rdy !== 1'b0) begin bad++; $display("FAIL reset_pkt_rdy got=%b want=0", a_packet_rdy); end
        total++; if (a_overflow !== 1'b0 || a_overrun !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b want=00", a_overflow, a_overrun); end
        total++; if (b_empty !== 1'b1 || c_empty !== 1'b1) begin bad++; $display("FAIL reset_empty_bc got=%b%b want=11", b_empty, c_empty); end
    endtask

    task automatic test_basic();
        do_reset();
        a_data_in   = {16'd1000, 16'd0};
        a_wr_strobe = 1'b1;
        tick();
        a_wr_strobe = 1'b0;
        exp_q.push_back(16'd0);
        exp_q.push_back(16'd1000);
        total++; if (a_used !== 6'd0) begin bad++; $display("FAIL basic_used_t0 got=%0d want=0", a_used); end
        tick();
        total++; if (a_used !== 6'd1) begin bad++; $display("FAIL basic_used_t1 got=%0d want=1", a_used); end
        tick();
        total++; if (a_used !== 6'd2) begin bad++; $display("FAIL basic_used_t2 got=%0d want=2", a_used); end
        for (int n = 1; n < 8; n++) begin
            tick();
            a_send(16'(n), 16'(n + 1000));
            repeat (4) tick();
        end
        total++; if (a_used !== 6'd16 || a_empty !== 1'b0) begin bad++; $display("FAIL basic_filled got used=%0d empty=%b want 16/0", a_used, a_empty); end
        a_burst("basic");
        total++; if (a_used !== 6'd0 || a_empty !== 1'b1) begin bad++; $display("FAIL basic_drained got used=%0d empty=%b want 0/1", a_used, a_empty); end
        total++; if (a_rd_data !== 16'd1007) begin bad++; $display("FAIL basic_hold got=%0d want=1007", a_rd_data); end
    endtask

    task automatic test_overrun();
        do_reset();
        a_data_in   = {16'h2222, 16'h1111};
        a_wr_strobe = 1'b1;
        tick();
        a_wr_strobe = 1'b0;
        tick();
        a_data_in   = {16'h4444, 16'h3333};
        a_wr_strobe = 1'b1;
        tick();
        a_wr_strobe = 1'b0;
        exp_q.push_back(16'h1111);
        exp_q.push_back(16'h2222);
        total++; if (a_overrun !== 1'b1) begin bad++; $display("FAIL overrun_flag got=%b want=1", a_overrun); end
        total++; if (a_used !== 6'd2) begin bad++; $display("FAIL overrun_used got=%0d want=2", a_used); end
        for (int k = 0; k < 7; k++) a_send(16'(16'h0100 + 2 * k), 16'(16'h0101 + 2 * k));
        total++; if (a_overrun !== 1'b1 || a_overflow !== 1'b0) begin bad++; $display("FAIL overrun_sticky got ovr=%b ovf=%b want 1/0", a_overrun, a_overflow); end
        a_burst("overrun");
        a_clear_status = 1'b1;
        tick();
        a_clear_status = 1'b0;
        total++; if (a_overrun !== 1'b0) begin bad++; $display("FAIL overrun_clear got=%b want=0", a_overrun); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int s = 0; s < 6; s++) begin
            c_data_in   = {16'(3 * s + 2), 16'(3 * s + 1), 16'(3 * s)};
            c_wr_strobe = 1'b1;
            tick();
            c_wr_strobe = 1'b0;
            repeat (3) tick();
            if (s == 4) begin
                total++; if (c_used !== 5'd15 || c_overflow !== 1'b0) begin bad++; $display("FAIL overflow_pre got used=%0d ovf=%b want 15/0", c_used, c_overflow); end
            end
        end
        total++; if (c_used !== 5'd15) begin bad++; $display("FAIL overflow_used got=%0d want=15", c_used); end
        total++; if (c_overflow !== 1'b1) begin bad++; $display("FAIL overflow_flag got=%b want=1", c_overflow); end
        total++; if (c_full !== 1'b0 || c_packet_rdy !== 1'b0) begin bad++; $display("FAIL overflow_full_rdy got=%b%b want=00", c_full, c_packet_rdy); end
        c_clear_status = 1'b1;
        c_wr_strobe    = 1'b1;
        tick();
        c_clear_status = 1'b0;
        c_wr_strobe    = 1'b0;
        total++; if (c_overflow !== 1'b1) begin bad++; $display("FAIL overflow_clear_race got=%b want=1", c_overflow); end
        c_clear_status = 1'b1;
        tick();
        c_clear_status = 1'b0;
        total++; if (c_overflow !== 1'b0 || c_used !== 5'd15) begin bad++; $display("FAIL overflow_clear got ovf=%b used=%0d want 0/15", c_overflow, c_used); end
    endtask

    task automatic test_wrap();
        int n;
        int run;
        int words;
        logic [15:0] v0, v1, want;
        do_reset();
        n = 0; run = 0; words = 0;
        a_rd_start = 1'b1;
        for (int cyc = 0; cyc < 660; cyc++) begin
            if (cyc < 600 && cyc % 3 == 0) begin
                v0 = 16'(2 * n);
                v1 = 16'(2 * n + 1);
                n++;
                a_data_in   = {v1, v0};
                a_wr_strobe = 1'b1;
                exp_q.push_back(v0);
                exp_q.push_back(v1);
            end else begin
                a_wr_strobe = 1'b0;
            end
            tick();
            if (a_rd_valid) begin
                run++;
                words++;
                if (exp_q.size() == 0) begin
                    total++; bad++; $display("FAIL wrap_extra_word got data=%h want no word", a_rd_data);
                end else begin
                    want = exp_q.pop_front();
                    total++; if (a_rd_data !== want) begin bad++; $display("FAIL wrap_word%0d got=%h want=%h", words, a_rd_data, want); end
                end
            end else if (run != 0) begin
                total++; if (run != 16) begin bad++; $display("FAIL wrap_burst_len got=%0d want=16", run); end
                run = 0;
            end
        end
        a_wr_strobe = 1'b0;
        a_rd_start  = 1'b0;
        total++; if (words != 400) begin bad++; $display("FAIL wrap_words got=%0d want=400", words); end
        total++; if (a_used !== 6'd0 || a_empty !== 1'b1) begin bad++; $display("FAIL wrap_drained got used=%0d empty=%b want 0/1", a_used, a_empty); end
        total++; if (a_overflow !== 1'b0 || a_overrun !== 1'b0) begin bad++; $display("FAIL wrap_flags got=%b%b want=00", a_overflow, a_overrun); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        a_data_in   = {16'h5151, 16'h5050};
        a_wr_strobe = 1'b1;
        tick();
        a_wr_strobe = 1'b0;
        tick();
        a_wr_strobe = 1'b1;
        tick();
        a_wr_strobe = 1'b0;
        for (int k = 0; k < 7; k++) a_send(16'(16'h0200 + k), 16'(16'h0300 + k));
        total++; if (a_overrun !== 1'b1 || a_packet_rdy !== 1'b1) begin bad++; $display("FAIL midrst_setup got ovr=%b rdy=%b want 1/1", a_overrun, a_packet_rdy); end
        a_rd_start = 1'b1;
        tick();
        a_rd_start = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        total++; if (a_used !== 6'd0 || a_empty !== 1'b1) begin bad++; $display("FAIL midrst_used got used=%0d empty=%b want 0/1", a_used, a_empty); end
        total++; if (a_rd_valid !== 1'b0 || a_rd_data !== 16'h0 || a_packet_rdy !== 1'b0) begin bad++; $display("FAIL midrst_rd got valid=%b data=%h rdy=%b want 0/0000/0", a_rd_valid, a_rd_data, a_packet_rdy); end
        total++; if (a_overrun !== 1'b0 || a_overflow !== 1'b0) begin bad++; $display("FAIL midrst_flags got=%b%b want=00", a_overrun, a_overflow); end
        tick();
        total++; if (a_rd_valid !== 1'b0) begin bad++; $display("FAIL midrst_burst_dead got=%b want=0", a_rd_valid); end
        a_data_in   = {16'h0009, 16'h0008};
        a_wr_strobe = 1'b1;
        tick();
        a_wr_strobe = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        tick();
        total++; if (a_used !== 6'd0) begin bad++; $display("FAIL shiftrst_used got=%0d want=0", a_used); end
        a_send(16'hAAAA, 16'hBBBB);
        for (int k = 1; k < 8; k++) a_send(16'(16'h0400 + k), 16'(16'h0500 + k));
        a_burst("after_reset");
    endtask

    task automatic test_boundary();
        do_reset();
        for (int k = 0; k < 16; k++) begin
            b_data_in   = 16'(16'h0B00 + k);
            b_wr_strobe = 1'b1;
            tick();
            b_wr_strobe = 1'b0;
            tick();
            if (k == 14) begin
                total++; if (b_used !== 5'd15 || b_packet_rdy !== 1'b0 || b_full !== 1'b0) begin bad++; $display("FAIL bound_15 got used=%0d rdy=%b full=%b want 15/0/0", b_used, b_packet_rdy, b_full); end
            end
        end
        total++; if (b_used !== 5'd16 || b_full !== 1'b1 || b_packet_rdy !== 1'b1) begin bad++; $display("FAIL bound_16 got used=%0d full=%b rdy=%b want 16/1/1", b_used, b_full, b_packet_rdy); end
        b_data_in   = 16'hDEAD;
        b_wr_strobe = 1'b1;
        tick();
        b_wr_strobe = 1'b0;
        tick();
        total++; if (b_overflow !== 1'b1 || b_used !== 5'd16) begin bad++; $display("FAIL bound_full_drop got ovf=%b used=%0d want 1/16", b_overflow, b_used); end
        b_clear_status = 1'b1;
        tick();
        b_clear_status = 1'b0;
        b_rd_start     = 1'b1;
        tick();
        b_rd_start     = 1'b0;
        total++; if (b_packet_rdy !== 1'b0) begin bad++; $display("FAIL bound_rdy_drop got=%b want=0", b_packet_rdy); end
        for (int j = 0; j < 16; j++) begin
            if (j == 1) begin
                b_data_in   = 16'h0BFF;
                b_wr_strobe = 1'b1;
            end
            tick();
            b_wr_strobe = 1'b0;
            total++;
            if (b_rd_valid !== 1'b1 || b_rd_data !== 16'(16'h0B00 + j)) begin
                bad++; $display("FAIL bound_word%0d got valid=%b data=%h want valid=1 data=%h", j, b_rd_valid, b_rd_data, 16'(16'h0B00 + j));
            end
        end
        tick();
        total++; if (b_rd_valid !== 1'b0) begin bad++; $display("FAIL bound_valid_end got=%b want=0", b_rd_valid); end
        total++; if (b_used !== 5'd1 || b_empty !== 1'b0 || b_full !== 1'b0) begin bad++; $display("FAIL bound_after got used=%0d empty=%b full=%b want 1/0/0", b_used, b_empty, b_full); end
        total++; if (b_overflow !== 1'b0) begin bad++; $display("FAIL bound_accept got ovf=%b want=0", b_overflow); end
    endtask

    initial begin
        reset          = 1'b1;
        a_wr_strobe    = 1'b0; a_rd_start = 1'b0; a_clear_status = 1'b0; a_data_in = '0;
        b_wr_strobe    = 1'b0; b_rd_start = 1'b0; b_clear_status = 1'b0; b_data_in = '0;
        c_wr_strobe    = 1'b0; c_rd_start = 1'b0; c_clear_status = 1'b0; c_data_in = '0;
        test_reset();
        test_basic();
        test_overrun();
        test_overflow();
        test_wrap();
        test_reset_mid();
        test_boundary();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
